// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: FSM states, funct3
// access encodings, exception causes and the default bus timeout.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] gives the access width, funct3[2] selects zero-extension
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT    = 4'd7;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational lane select and sign/zero extension of a read word;
// shared with the future fetch path.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic        sign_ext;

  always_comb begin
    byte_val = rdata[{lane, 3'b000} +: 8];
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];
    sign_ext = ~size[2];
    case (size[1:0])
      SZ_BYTE: data = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: data = {{16{sign_ext & half_val[15]}}, half_val};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: one load or store per active stage, with misalignment and
// bus-fault detection, fully registered outputs and a bus timeout.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        active,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        done,
  output logic [31:0] load_data,
  output logic        exc,
  output logic [3:0]  exc_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_error
);

  state_e      state_q, state_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] load_data_q, load_data_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;

  logic [31:0] aligned;
  logic        misaligned;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  load_align u_load_align (
    .rdata (bus_rdata),
    .lane  (lane_q),
    .size  (size_q),
    .data  (aligned)
  );

  always_comb begin
    misaligned = ((size[1:0] == SZ_HALF) && addr[0]) ||
                 (size[1] && (addr[1:0] != 2'b00));
    case (size[1:0])
      SZ_BYTE: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    exc_d       = exc_q;
    cause_d     = cause_q;
    load_data_d = load_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    size_d      = size_q;
    lane_d      = lane_q;

    case (state_q)
      ST_IDLE: begin
        if (active) begin
          is_load_d = mem_read;
          size_d    = size;
          lane_d    = addr[1:0];
          if (!(mem_read || mem_write)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            exc_d   = 1'b0;
            cause_d = 4'd0;
          end else if (misaligned) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            exc_d   = 1'b1;
            cause_d = mem_read ? CAUSE_LOAD_MISALIGN : CAUSE_STORE_MISALIGN;
          end else begin
            state_d     = ST_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = wdata;
            bus_wstrb_d = wstrb;
            cnt_d       = 8'(TIMEOUT);
          end
        end
      end

      ST_BUS: begin
        // The request is withdrawn one cycle before a timeout is reported
        if (!active) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          exc_d   = 1'b1;
          cause_d = is_load_q ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
        end else if (bus_ready) begin
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (bus_error) begin
            exc_d   = 1'b1;
            cause_d = is_load_q ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
          end else if (is_load_q) begin
            load_data_d = aligned;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) bus_req_d = 1'b0;
        end
      end

      ST_DONE: begin
        if (!active) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
          exc_d   = 1'b0;
          cause_d = 4'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      exc_q       <= 1'b0;
      cause_q     <= 4'd0;
      load_data_q <= 32'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'd0;
      cnt_q       <= 8'd0;
      is_load_q   <= 1'b0;
      size_q      <= 3'd0;
      lane_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      exc_q       <= exc_d;
      cause_q     <= cause_d;
      load_data_q <= load_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
    end
  end

  assign done      = done_q;
  assign exc       = exc_q;
  assign exc_cause = cause_q;
  assign load_data = load_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-stage unit of the multi-cycle core. While its stage is active it performs at most one load or store on the data bus, aligns and extends load data, flags misalignment and bus faults, and raises its `done` bit for the stage sequencer. It consumes the sequencer's MEMORY `stage_active` bit and produces the matching `stage_done` bit. It sits between the execute results and write-back.

## Interface
- `TIMEOUT`, default 255: bus-wait cycles before a transfer is aborted as an access fault (1..255).
- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `active`  in  1  MEMORY stage_active bit from the sequencer.
- `mem_read`  in  1  instruction is a load; stable while `active`.
- `mem_write`  in  1  instruction is a store; never high together with `mem_read`.
- `size`  in  3  funct3 access type (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `addr`  in  32  byte address from execute.
- `store_data`  in  32  rs2 value, LSB-aligned.
- `done`  out  1  MEMORY stage_done bit.
- `load_data`  out  32  aligned and extended load result; held until the next load completes.
- `exc`  out  1  exception raised by this access.
- `exc_cause`  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault.
- `bus_req`  out  1  transfer request.
- `bus_we`  out  1  write enable.
- `bus_addr`  out  32  word address; bits [1:0] are always 0.
- `bus_wdata`  out  32  store data shifted into byte lanes.
- `bus_wstrb`  out  4  byte-lane write strobes.
- `bus_ready`  in  1  completes the transfer in the cycle it is sampled high.
- `bus_rdata`  in  32  read word; valid when `bus_ready` is high.
- `bus_error`  in  1  qualifies `bus_ready`; the transfer failed.

## Operation
- States: IDLE, BUS, DONE.
- IDLE:
  - Waits for `active`.
  - No access requested: go to DONE, `exc` = 0.
  - Misaligned access (half with addr[0] = 1, or word with addr[1:0] ≠ 0): go to DONE with `exc` = 1 and cause 4 or 6. No bus request is issued.
  - Otherwise: register the bus outputs, load the timeout counter with `TIMEOUT`, go to BUS.
- BUS:
  - `bus_req` is high and all bus outputs are held stable.
  - Counter decrements once per cycle.
  - `bus_ready` & !`bus_error`: update `load_data` (loads only), go to DONE.
  - `bus_ready` & `bus_error`, or counter reaches 0 without `bus_ready`: go to DONE with `exc` = 1, cause 5 or 7. `load_data` is unchanged.
- DONE:
  - `done` is high and `exc`/`exc_cause` are held.
  - When `active` falls: go to IDLE; `done`, `exc` and `exc_cause` clear.
- `active` dropping in BUS is a sequencer error. Abandon the transfer and return to IDLE.
- Load alignment: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend; LBU/LHU zero-extend.
- Store: `bus_wdata` = byte replicated ×4 or half replicated ×2. `bus_wstrb` = 0001 << addr[1:0] for bytes, 0011 << (2·addr[1]) for halves, 1111 for words.

## Timing
- Reset values: state IDLE; `done`, `exc`, `bus_req`, `bus_we` = 0; `exc_cause`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `load_data` = 0.
- All outputs are registered. There is no combinational path from bus inputs to outputs.
- `done` is never high in the first `active` cycle, as the sequencer requires.
- No-op or misaligned access: `done` is high 1 cycle after `active` rises.
- Bus access: `bus_req` rises 1 cycle after `active`. `done` rises 1 cycle after `bus_ready` is sampled. Minimum latency is 2 cycles after `active` if `bus_ready` is already high.
- Timeout: `done` rises `TIMEOUT` + 1 cycles after `bus_req` rises.
- `bus_req` drops in the cycle after `bus_ready` is sampled. Back-to-back requests cannot occur.
- Asynchronous reset mid-transfer: `bus_req` drops immediately. The bus must tolerate abandoned requests.

## Structure
- `mem_pkg`:
  - State enum.
  - funct3 size encodings.
  - Exception cause constants 4–7.
  - `TIMEOUT` default.
- Sub-module `load_align` (combinational): lane select plus sign/zero extension from `bus_rdata`, addr[1:0] and `size`. Reused by a future fetch path.

## Test plan
- LW at 0x100, `bus_rdata` = 0xDEADBEEF, `bus_ready` 2 cycles after `bus_req` → `load_data` = 0xDEADBEEF, `done` 4 cycles after `active`, `exc` = 0.
- LB / LBU at 0x103, `bus_rdata` = 0x80123456 → LB gives 0xFFFFFF80, LBU gives 0x00000080, `bus_addr` = 0x100.
- SH at 0x202, `store_data` = 0x00001234 → `bus_wdata` = 0x12341234, `bus_wstrb` = 1100, `bus_we` = 1.
- LW at 0x102 → no `bus_req`, `done` 1 cycle after `active`, `exc` = 1, cause 4. SW at 0x101 → cause 6.
- SW with `bus_ready` never asserted, `TIMEOUT` = 3 → `bus_req` for 3 cycles, `exc` = 1, cause 7. Load with `bus_ready` & `bus_error` → cause 5, `load_data` unchanged.
- `reset_n` low during BUS → `bus_req` and `done` go to 0 immediately. Next access after reset completes normally.
